// File: rtl/spi_pkg.sv
// Shared SPI definitions used by spi_master and spi_slave_unit.
// Provides the SPCON bit positions, a packed view of the SPCON register,
// the byte width, and a helper that picks a bit of a byte in either shift order.
package spi_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;

  // SPCON bit positions
  localparam int SPEN = 0;
  localparam int CPHA = 1;
  localparam int CPOL = 2;
  localparam int LSBF = 3;

  typedef struct packed {
    logic [3:0] reserved;
    logic       lsbf;
    logic       cpol;
    logic       cpha;
    logic       spen;
  } spcon_t;

  // Bit number idx of a byte as it travels on the wire: idx 0 is the first bit sent.
  // For MSB-first, ~idx on a 3-bit index is 7-idx.
  function automatic logic bit_sel(input logic [BYTE_W-1:0]    b,
                                   input logic [BIT_CNT_W-1:0] idx,
                                   input logic                 lsbf);
    return lsbf ? b[idx] : b[~idx];
  endfunction

endpackage

// File: rtl/spi_slave_unit_if.sv
// SPI bus bundle shared between a master and a slave.
// Signals:
//   sck   serial clock, driven by the master
//   ssn   slave select (active-low), driven by the master
//   mosi  master-out serial data
//   miso  slave-out serial data
// Modports: master drives sck/ssn/mosi and reads miso; slave is the mirror image.
interface spi_slave_unit_if;

  logic sck;
  logic ssn;
  logic mosi;
  logic miso;

  modport master (output sck, output ssn, output mosi, input miso);
  modport slave  (input sck, input ssn, input mosi, output miso);

endinterface

// File: rtl/spi_sync.sv
// N-flop synchronizer for a single asynchronous input.
// Parameters:
//   STAGES   number of flops in the chain (2 or more)
//   RST_VAL  value every flop takes in reset
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   d      asynchronous input
//   q      synchronized output, STAGES clocks behind d
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_unit.sv
// Byte-oriented SPI slave supporting all four CPOL/CPHA modes, oversampled in
// the system clock domain. Shifts out a byte taken from data while assembling a
// byte from mosi; consecutive bytes are supported while ssn stays low.
// Parameters:
//   SYNC_STAGES  flops in each of the sck/ssn/mosi synchronizers (min 2)
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   data     transmit byte, loaded at frame start and at every byte wrap
//   spcon    control: [0] SPEN, [1] CPHA, [2] CPOL, [3] LSBF, [7:4] ignored
//   spibr    baud divider, master-only, ignored here
//   bus      SPI bus (slave modport): sck, ssn, mosi in; miso out
//   rx_data  last complete received byte
//   rx_done  one-clock pulse when rx_data updates
module spi_slave_unit
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] data,
  input  logic [7:0]        spcon,
  input  logic [7:0]        spibr,
  spi_slave_unit_if.slave   bus,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_done
);

  spcon_t cfg;
  assign cfg = spcon_t'(spcon);

  // spibr and the reserved SPCON bits have no meaning on the slave side
  logic unused_bits;
  assign unused_bits = ^{spibr, cfg.reserved};

  // Identical synchronizers keep mosi aligned with sck; ssn idles deselected
  logic sck_s, ssn_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.sck),
    .q    (sck_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssn (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.ssn),
    .q    (ssn_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.mosi),
    .q    (mosi_s)
  );

  // Previous synchronized sck/ssn for edge detection
  logic sck_d, ssn_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_d <= 1'b0;
      ssn_d <= 1'b1;
    end else begin
      sck_d <= sck_s;
      ssn_d <= ssn_s;
    end
  end

  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BYTE_W-1:0]    tx_sreg;
  logic [BYTE_W-1:0]    rx_sreg;
  logic                 first_lead;
  logic                 miso_q;

  logic              nsck, nsck_d;
  logic              lead_edge, trail_edge;
  logic              active, frame_start;
  logic              sample_edge, shift_edge;
  logic              last_bit;
  logic [BYTE_W-1:0] rx_next;

  // Normalizing by CPOL makes the leading edge always a 0->1 transition.
  // The cycle that sees the ssn fall only loads the frame; edges are ignored then.
  always_comb begin
    nsck        = sck_s ^ cfg.cpol;
    nsck_d      = sck_d ^ cfg.cpol;
    lead_edge   = nsck & ~nsck_d;
    trail_edge  = ~nsck & nsck_d;
    active      = cfg.spen & ~ssn_s;
    frame_start = active & ssn_d;
    sample_edge = active & ~frame_start & (cfg.cpha ? trail_edge : lead_edge);
    // With CPHA=1 the first bit is already on miso, so the first leading edge must not shift
    shift_edge  = active & ~frame_start &
                  (cfg.cpha ? (lead_edge & ~first_lead) : trail_edge);
    last_bit    = (bit_cnt == BIT_CNT_W'(BYTE_W - 1));
    rx_next     = cfg.lsbf ? {mosi_s, rx_sreg[BYTE_W-1:1]}
                           : {rx_sreg[BYTE_W-2:0], mosi_s};
  end

  // tx_sreg holds the whole byte; miso is picked from it by bit_cnt so that a
  // reload at the byte wrap is seen by the very next shift edge.
  // Deselecting (ssn high or SPEN low) always wins over a coincident sample edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      tx_sreg    <= '0;
      rx_sreg    <= '0;
      first_lead <= 1'b0;
      miso_q     <= 1'b0;
      rx_data    <= '0;
      rx_done    <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (!active) begin
        bit_cnt    <= '0;
        first_lead <= 1'b0;
        miso_q     <= 1'b0;
      end else if (frame_start) begin
        tx_sreg    <= data;
        miso_q     <= bit_sel(data, '0, cfg.lsbf);
        bit_cnt    <= '0;
        first_lead <= 1'b1;
      end else begin
        if (lead_edge) begin
          first_lead <= 1'b0;
        end
        if (sample_edge) begin
          rx_sreg <= rx_next;
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          if (last_bit) begin
            rx_data <= rx_next;
            rx_done <= 1'b1;
            tx_sreg <= data;
          end
        end
        if (shift_edge) begin
          miso_q <= bit_sel(tx_sreg, bit_cnt, cfg.lsbf);
        end
      end
    end
  end

  assign bus.miso = miso_q;

endmodule

// File: tb/tb_spi_slave_unit.sv
// Self-checking bench for spi_slave_unit. A behavioural SPI master drives the
// bus; every byte the master fully sends is pushed to a scoreboard and popped
// when the slave pulses rx_done. The byte the master collects from miso is
// compared against the slave's transmit data.
module tb_spi_slave_unit;

  localparam int HALF = 8;  // sck half-period in clk cycles

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic [7:0] spcon;
  logic [7:0] spibr;
  logic [7:0] rx_data;
  logic       rx_done;

  spi_slave_unit_if bus ();

  spi_slave_unit #(.SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (data),
    .spcon  (spcon),
    .spibr  (spibr),
    .bus    (bus),
    .rx_data(rx_data),
    .rx_done(rx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         testsRun  = 0;
  int         failCount = 0;
  int         doneCount = 0;
  logic [7:0] sbQ[$];
  logic [7:0] expByte;
  logic       prevDone = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard consumer: every rx_done pops one expected byte; pulses must be one clk wide
  always @(negedge clk) begin
    if (rst_n && rx_done) begin
      doneCount++;
      if (sbQ.size() == 0) begin
        checkOutput("rx_unexpected", 32'd1, 32'd0);
      end else begin
        expByte = sbQ.pop_front();
        checkOutput("rx_data", 32'(rx_data), 32'(expByte));
      end
      if (prevDone) checkOutput("rx_done_width", 32'd2, 32'd1);
    end
    prevDone = rx_done;
  end

  // Master side of one byte (or a partial byte of nbits). The master samples miso
  // on its own sample edge and optionally changes the slave's data after bit 3.
  task automatic applyStimulus(input logic [7:0] cfg, input logic [7:0] mbyte, input int nbits,
                               input bit pushExp, input bit swapData, input logic [7:0] newData,
                               output logic [7:0] mrx);
    logic cpol, cpha, lsbf, b;
    cpol = cfg[2];
    cpha = cfg[1];
    lsbf = cfg[3];
    mrx  = 8'h00;
    if (pushExp) sbQ.push_back(mbyte);
    for (int i = 0; i < nbits; i++) begin
      b = lsbf ? mbyte[i] : mbyte[7-i];
      if (!cpha) begin
        bus.mosi = b;
        waitClk(HALF);
        bus.sck = ~cpol;
        mrx[lsbf ? i : 7-i] = bus.miso;
        waitClk(HALF);
        bus.sck = cpol;
      end else begin
        waitClk(HALF);
        bus.sck  = ~cpol;
        bus.mosi = b;
        waitClk(HALF);
        bus.sck = cpol;
        mrx[lsbf ? i : 7-i] = bus.miso;
      end
      if (swapData && i == 3) data = newData;
    end
  endtask

  // One selected frame carrying a single (possibly partial) byte
  task automatic runFrame(input logic [7:0] cfg, input logic [7:0] sdata, input logic [7:0] mbyte,
                          input int nbits, input logic [7:0] expMiso, input int expDone,
                          input string tag);
    logic [7:0] mrx;
    int         startCount;
    spcon    = cfg;
    data     = sdata;
    bus.sck  = cfg[2];
    bus.mosi = 1'b0;
    waitClk(HALF);
    startCount = doneCount;
    bus.ssn = 1'b0;
    waitClk(HALF);
    applyStimulus(cfg, mbyte, nbits, (expDone > 0), 1'b0, 8'h00, mrx);
    waitClk(HALF);
    bus.ssn = 1'b1;
    waitClk(2*HALF);
    if (nbits == 8) checkOutput({tag, "_miso_byte"}, 32'(mrx), 32'(expMiso));
    checkOutput({tag, "_pulses"}, 32'(doneCount - startCount), 32'(expDone));
    checkOutput({tag, "_pending"}, 32'(sbQ.size()), 32'd0);
    checkOutput({tag, "_idle_miso"}, 32'(bus.miso), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] mrx1, mrx2;
    int         startCount;

    rst_n    = 1'b0;
    data     = 8'h00;
    spcon    = 8'h00;
    spibr    = 8'h04;
    bus.sck  = 1'b0;
    bus.ssn  = 1'b1;
    bus.mosi = 1'b0;

    // Reset held while the bus wiggles
    for (int i = 0; i < 4; i++) begin
      bus.sck = ~bus.sck;
      bus.ssn = ~bus.ssn;
      spcon   = 8'h01;
      waitClk(3);
      checkOutput("rst_miso", 32'(bus.miso), 32'd0);
      checkOutput("rst_rx_done", 32'(rx_done), 32'd0);
      checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
    end
    bus.sck = 1'b0;
    bus.ssn = 1'b1;
    waitClk(2);
    rst_n = 1'b1;
    waitClk(5);

    // Mode 0 full duplex
    runFrame(8'h01, 8'h3C, 8'hA5, 8, 8'h3C, 1, "mode0");

    // Disabled slave: no reception, miso quiet
    runFrame(8'h00, 8'hFF, 8'hFF, 8, 8'h00, 0, "disabled");
    checkOutput("disabled_rx_hold", 32'(rx_data), 32'hA5);

    // Remaining modes
    runFrame(8'h07, 8'h42, 8'h81, 8, 8'h42, 1, "mode3");
    runFrame(8'h03, 8'h99, 8'h7E, 8, 8'h99, 1, "mode1");
    runFrame(8'h05, 8'h24, 8'h7E, 8, 8'h24, 1, "mode2");

    // Abort after 4 bits, then a clean frame
    runFrame(8'h01, 8'h11, 8'hF0, 4, 8'h00, 0, "abort");
    checkOutput("abort_rx_hold", 32'(rx_data), 32'h7E);
    runFrame(8'h01, 8'hE7, 8'h5A, 8, 8'hE7, 1, "after_abort");

    // LSB-first, two bytes back to back; second tx byte comes from data at the wrap
    spcon    = 8'h09;
    data     = 8'h96;
    bus.sck  = 1'b0;
    waitClk(HALF);
    startCount = doneCount;
    bus.ssn = 1'b0;
    waitClk(HALF);
    applyStimulus(8'h09, 8'hC3, 8, 1'b1, 1'b1, 8'h66, mrx1);
    applyStimulus(8'h09, 8'h12, 8, 1'b1, 1'b0, 8'h00, mrx2);
    waitClk(HALF);
    bus.ssn = 1'b1;
    waitClk(2*HALF);
    checkOutput("b2b_miso_byte0", 32'(mrx1), 32'h96);
    checkOutput("b2b_miso_byte1", 32'(mrx2), 32'h66);
    checkOutput("b2b_pulses", 32'(doneCount - startCount), 32'd2);
    checkOutput("b2b_pending", 32'(sbQ.size()), 32'd0);
    checkOutput("b2b_last_rx", 32'(rx_data), 32'h12);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
